spi_cmd_sniffer: RTL and testbench
==================================

# spi_cmd_sniffer

Passive, parametrised SPI bus sniffer that watches CSN/SCK/MOSI/MISO for frames whose command field matches a programmable, maskable command. It captures the following payload from both MOSI and MISO and queues it in a small FIFO. Any of the four SPI modes can be selected, and it runs in single-shot or continuous mode. It sits beside the monitored bus in the FPGA fabric and feeds a host-side reader over a valid/ready handshake.

## Interface
Parameters:
- CMD_W, 8, command field width in bits (1..16)
- DATA_W, 8, payload width in bits (1..32)
- FIFO_DEPTH, 4, captured-frame FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock; all logic is on posedge clk
- rst  in  1  asynchronous, active-high reset
- start  in  1  arms the sniffer; accepted only in IDLE
- continuous  in  1  latched at start; 1 = re-arm after each match
- cpol, cpha  in  1 each  SPI mode, latched at start
- CSN, SCK, MOSI, MISO  in  1 each  monitored bus (asynchronous to clk)
- cmd  in  CMD_W  command to match
- cmd_mask  in  CMD_W  1 = bit compared, 0 = don't care
- armed  out  1  high in WAIT_CS and SHIFT
- data_valid  out  1  FIFO non-empty
- data_ready  in  1  pops the FIFO head when data_valid=1
- mosi_data, miso_data  out  DATA_W each  FIFO head payload (first-word fall-through)
- overflow  out  1  sticky; a matched frame was dropped because the FIFO was full
- len_err_cnt  out  8  saturating count of armed frames with the wrong bit count

## Operation
- Each of CSN, SCK, MOSI and MISO passes through a 2-flop synchronizer plus one edge-detect register.
- Sample edge is SCK rising when cpol^cpha = 0, SCK falling otherwise. This covers all four modes.
- States:
  - IDLE → WAIT_CS on start. Mode and continuous are latched at that point; overflow is cleared.
  - WAIT_CS → SHIFT on a CSN falling edge. bitcnt and the shift registers are cleared.
  - SHIFT: on each sample edge, shift MOSI and MISO in MSB-first, into separate (CMD_W+DATA_W)-bit registers.
  - bitcnt saturates at CMD_W+DATA_W+1 and never wraps.
- On a CSN rising edge in SHIFT, a frame matches when:
  - bitcnt == CMD_W+DATA_W, and
  - ((mosi_sr[top CMD_W] ^ cmd) & cmd_mask) == 0.
- On a match:
  - Push {mosi_sr[DATA_W-1:0], miso_sr[DATA_W-1:0]} into the FIFO.
  - If the FIFO is full and no pop happens that cycle, drop the frame and set overflow.
  - Next state: WAIT_CS if continuous, else IDLE.
- On a non-match: next state is WAIT_CS.
  - If bitcnt ≠ CMD_W+DATA_W, len_err_cnt increments (saturates at 255).
  - A length-correct frame with the wrong command is not an error.
- Simultaneous and boundary events:
  - CSN edges seen in IDLE are ignored. A frame already in progress when the sniffer is armed is not captured; capture waits for the next CSN falling edge.
  - A CSN rising edge in WAIT_CS is ignored.
  - start outside IDLE is ignored.
  - If a sample edge and the CSN rising edge are detected in the same cycle, that bit is shifted in and included in the match check.
- FIFO:
  - Pop on data_valid && data_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (no overflow).
  - Popping when empty has no effect.
- Changing cmd or cmd_mask takes effect at the next check. They are sampled in the CSN-rising cycle.

## Timing
- Reset values: IDLE, armed=0, data_valid=0, mosi_data=miso_data=0, overflow=0, len_err_cnt=0, FIFO empty, synchronizers=all ones for CSN, 0 for the other inputs.
- Reset mid-frame aborts immediately. Nothing is pushed.
- Bus-to-detection latency: 3 clk from a pin transition to the edge strobe.
- Bus constraint: SCK high and low phases ≥ 3 clk each. CSN inactive gap ≥ 3 clk.
- A match is pushed in the cycle after CSN-rising detection. data_valid rises 1 clk after the push; the head data is valid in the same cycle.
- armed falls in the push cycle in single-shot mode.
- A pop updates the head and data_valid on the next clk edge.

## Test plan
- Mode 0, cmd=0xA5, mask=0xFF, single-shot; frame MOSI A5 3C, MISO 00 C3 → one entry mosi=0x3C miso=0xC3; state IDLE; armed=0.
- Modes 1, 2 and 3 (each with matching cpol/cpha), continuous; three frames A5 11, 5A 22, A5 33 → FIFO holds 0x11, 0x33; 5A frame dropped; len_err_cnt=0.
- mask=0xF0, cmd=0xA0; frame A7 44 → captured 0x44. 15-bit frame → len_err_cnt=1, no push. 17-bit frame → len_err_cnt=2.
- FIFO_DEPTH=4, continuous, data_ready=0; 5 matching frames → 4 entries, overflow=1. Pop all → values in order, data_valid=0 after the 4th pop.
- Full FIFO with data_ready=1 held during the 5th push → no overflow, 4 entries remain.
- Assert rst mid-SHIFT, then start, then a clean frame A5 77 → only 0x77 captured. Also: start during a frame in progress → that frame ignored, next frame captured.

Source files
------------

// File: rtl/spi_cmd_sniffer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_sniffer
// Purpose  : Passive SPI bus sniffer. Watches CSN/SCK/MOSI/MISO and, for
//            frames whose command field matches cmd (under cmd_mask), queues
//            the payload seen on both MOSI and MISO in a small FIFO.
//            Supports all four SPI modes, single-shot or continuous re-arm.
// Ports    : clk, rst (async, active-high)
//            start/continuous/cpol/cpha - arm control, latched on start
//            CSN/SCK/MOSI/MISO          - monitored bus (asynchronous)
//            cmd/cmd_mask               - command match value / care mask
//            armed                      - sniffer waiting for or in a frame
//            data_valid/data_ready      - FIFO head handshake (FWFT)
//            mosi_data/miso_data        - FIFO head payload
//            overflow                   - sticky, matched frame dropped
//            len_err_cnt                - saturating bad-length frame count
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_sniffer #(
    parameter int CMD_W      = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              CSN,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              MISO,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [CMD_W-1:0]  cmd_mask,
    output logic              armed,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [DATA_W-1:0] mosi_data,
    output logic [DATA_W-1:0] miso_data,
    output logic              overflow,
    output logic [7:0]        len_err_cnt
);

    localparam int c_TOT   = CMD_W + DATA_W;
    localparam int c_CNT_W = $clog2(c_TOT + 2);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_ENT_W = 2 * DATA_W;

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_TOT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(c_TOT + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT_CS = 2'd1;
    localparam logic [1:0] c_SHIFT   = 2'd2;

    // ------------------------------------------------------------------
    // Bus synchronizers; CSN idles high so its chain resets to ones.
    // ------------------------------------------------------------------
    logic r_csn_s1, r_csn_s2, r_csn_d;
    logic r_sck_s1, r_sck_s2, r_sck_d;
    logic r_mosi_s1, r_mosi_s2;
    logic r_miso_s1, r_miso_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csn_s1  <= 1'b1;
            r_csn_s2  <= 1'b1;
            r_csn_d   <= 1'b1;
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_csn_s1  <= CSN;
            r_csn_s2  <= r_csn_s1;
            r_csn_d   <= r_csn_s2;
            r_sck_s1  <= SCK;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
            r_miso_s1 <= MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    logic w_csn_fall, w_csn_rise, w_sck_rise, w_sck_fall;
    assign w_csn_fall = r_csn_d & ~r_csn_s2;
    assign w_csn_rise = ~r_csn_d & r_csn_s2;
    assign w_sck_rise = ~r_sck_d & r_sck_s2;
    assign w_sck_fall = r_sck_d & ~r_sck_s2;

    // ------------------------------------------------------------------
    // Control and capture state
    // ------------------------------------------------------------------
    logic [1:0]         r_state, w_state_next;
    logic               r_cont;
    logic               r_samp_fall;   // cpol^cpha: sample on falling SCK
    logic [c_CNT_W-1:0] r_bitcnt;
    logic [c_TOT-1:0]   r_mosi_sr;
    // Only the payload bits of MISO are ever reported, so only those are kept.
    logic [DATA_W-1:0]  r_miso_sr;
    logic               r_push;
    logic [c_ENT_W-1:0] r_push_data;
    logic               r_overflow;
    logic [7:0]         r_len_err;

    logic               w_sample;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_TOT-1:0]   w_mosi_next;
    logic [DATA_W-1:0]  w_miso_shift, w_miso_next;
    logic               w_end, w_len_ok, w_cmd_ok, w_match;
    logic               w_full, w_empty, w_pop, w_wr;

    assign w_sample = (r_state == c_SHIFT) &&
                      (r_samp_fall ? w_sck_fall : w_sck_rise);

    generate
        if (DATA_W == 1) begin : g_miso_1
            assign w_miso_shift = r_miso_s2;
        end else begin : g_miso_n
            assign w_miso_shift = {r_miso_sr[DATA_W-2:0], r_miso_s2};
        end
    endgenerate

    // "Next" views include a bit sampled in the same cycle as CSN rising,
    // so that bit takes part in the match check.
    assign w_cnt_next  = (w_sample && (r_bitcnt != c_CNT_MAX)) ? r_bitcnt + 1'b1 : r_bitcnt;
    assign w_mosi_next = w_sample ? {r_mosi_sr[c_TOT-2:0], r_mosi_s2} : r_mosi_sr;
    assign w_miso_next = w_sample ? w_miso_shift : r_miso_sr;

    assign w_end    = (r_state == c_SHIFT) && w_csn_rise;
    assign w_len_ok = (w_cnt_next == c_CNT_FULL);
    assign w_cmd_ok = (((w_mosi_next[c_TOT-1 -: CMD_W] ^ cmd) & cmd_mask) == '0);
    assign w_match  = w_end && w_len_ok && w_cmd_ok;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:    if (start) w_state_next = c_WAIT_CS;
            c_WAIT_CS: if (w_csn_fall) w_state_next = c_SHIFT;
            c_SHIFT:   if (w_csn_rise) w_state_next = (w_match && !r_cont) ? c_IDLE : c_WAIT_CS;
            default:   w_state_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        armed = (r_state == c_WAIT_CS) || (r_state == c_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cont      <= 1'b0;
            r_samp_fall <= 1'b0;
            r_bitcnt    <= '0;
            r_mosi_sr   <= '0;
            r_miso_sr   <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_overflow  <= 1'b0;
            r_len_err   <= '0;
        end else begin
            if ((r_state == c_IDLE) && start) begin
                r_cont      <= continuous;
                r_samp_fall <= cpol ^ cpha;
            end

            if ((r_state == c_WAIT_CS) && w_csn_fall) begin
                r_bitcnt  <= '0;
                r_mosi_sr <= '0;
                r_miso_sr <= '0;
            end else if (r_state == c_SHIFT) begin
                r_bitcnt  <= w_cnt_next;
                r_mosi_sr <= w_mosi_next;
                r_miso_sr <= w_miso_next;
            end

            // The push is staged one cycle after the CSN-rising check.
            r_push      <= w_match;
            r_push_data <= {w_mosi_next[DATA_W-1:0], w_miso_next};

            if (w_end && !w_len_ok && (r_len_err != 8'hFF))
                r_len_err <= r_len_err + 8'd1;

            if (r_push && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if ((r_state == c_IDLE) && start)
                r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Captured-frame FIFO, first-word fall-through
    // ------------------------------------------------------------------
    logic [c_PTR_W:0]   r_wr_ptr, r_rd_ptr;
    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_ENT_W-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_pop   = !w_empty && data_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= r_push_data;
    end

    assign w_head      = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign data_valid  = !w_empty;
    assign mosi_data   = w_empty ? '0 : w_head[c_ENT_W-1:DATA_W];
    assign miso_data   = w_empty ? '0 : w_head[DATA_W-1:0];
    assign overflow    = r_overflow;
    assign len_err_cnt = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_sniffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_sniffer
// Purpose  : Self-checking bench for spi_cmd_sniffer. Drives SPI frames in
//            all four modes and compares DUT outputs against a queue-based
//            reference model of the capture rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_sniffer;

    localparam int CMD_W      = 8;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TOT        = CMD_W + DATA_W;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, continuous = 1'b0;
    logic cpol = 1'b0, cpha = 1'b0;
    logic CSN = 1'b1, SCK = 1'b0, MOSI = 1'b0, MISO = 1'b0, data_ready = 1'b0;
    logic [CMD_W-1:0]  cmd = '0, cmd_mask = '0;
    logic              armed, data_valid, overflow;
    logic [DATA_W-1:0] mosi_data, miso_data;
    logic [7:0]        len_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [2*DATA_W-1:0] q[$];   // {mosi payload, miso payload}
    bit m_armed, m_cont, m_ovf;
    int m_len;
    bit b_cpol, b_cpha;          // bus mode used to generate SCK

    always #5 clk = ~clk;

    spi_cmd_sniffer #(.CMD_W(CMD_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .cpol(cpol), .cpha(cpha), .CSN(CSN), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .cmd(cmd), .cmd_mask(cmd_mask), .armed(armed), .data_valid(data_valid),
        .data_ready(data_ready), .mosi_data(mosi_data), .miso_data(miso_data),
        .overflow(overflow), .len_err_cnt(len_err_cnt)
    );

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_armed = 0; m_cont = 0; m_ovf = 0; m_len = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wclk(2);
        rst = 1'b0;
        model_reset();
        wclk(2);
    endtask

    // Arm; DUT mode inputs are scrambled afterwards since they must be latched.
    task automatic arm(input bit c, input bit pol, input bit pha);
        b_cpol = pol; b_cpha = pha;
        SCK = pol; cpol = pol; cpha = pha; continuous = c;
        wclk(4);
        start = 1'b1;
        wclk(1);
        start = 1'b0;
        cpol = 1'($urandom); cpha = 1'($urandom); continuous = 1'($urandom);
        if (!m_armed) begin
            m_armed = 1; m_cont = c; m_ovf = 0;
        end
    endtask

    task automatic put_bit(input logic mo, input logic mi);
        if (!b_cpha) begin
            MOSI = mo; MISO = mi; wclk(4);
            SCK = ~b_cpol; wclk(4);
            SCK = b_cpol;
        end else begin
            SCK = ~b_cpol; MOSI = mo; MISO = mi; wclk(4);
            SCK = b_cpol; wclk(4);
        end
    endtask

    // Frame rule: exactly TOT bits, masked command equal -> capture low DATA_W
    // bits of each line; otherwise wrong length counts as an error.
    task automatic model_end(input logic [63:0] mb, input logic [63:0] sb, input int n);
        logic [CMD_W-1:0]  c;
        logic [DATA_W-1:0] dm, ds;
        if (!m_armed) return;
        c  = CMD_W'(mb >> DATA_W);
        dm = DATA_W'(mb);
        ds = DATA_W'(sb);
        if (n == TOT && ((c ^ cmd) & cmd_mask) == '0) begin
            if (q.size() < FIFO_DEPTH) q.push_back({dm, ds});
            else m_ovf = 1;
            if (!m_cont) m_armed = 0;
        end else if (n != TOT && m_len < 255) begin
            m_len++;
        end
    endtask

    task automatic send_frame(input logic [63:0] mb, input logic [63:0] sb, input int n,
                              input bit simul, input bit pop_at_push);
        bit seen;
        logic [2*DATA_W-1:0] tmp;
        CSN = 1'b0; wclk(4);
        for (int i = 0; i < n - (simul ? 1 : 0); i++) put_bit(mb[n-1-i], sb[n-1-i]);
        if (simul) begin
            // last sample edge and CSN release land in the same clk cycle
            if (!b_cpha) begin
                MOSI = mb[0]; MISO = sb[0]; wclk(4);
                SCK = ~b_cpol; CSN = 1'b1; wclk(4);
                SCK = b_cpol;
            end else begin
                SCK = ~b_cpol; MOSI = mb[0]; MISO = sb[0]; wclk(4);
                SCK = b_cpol; CSN = 1'b1;
            end
        end else begin
            wclk(4);
            CSN = 1'b1;
        end
        if (pop_at_push) begin
            // single-shot: armed drops in the push cycle; pop in that same cycle
            seen = 0;
            for (int k = 0; k < 12 && !seen; k++) begin
                @(negedge clk);
                if (!armed) begin
                    seen = 1;
                    chk("pop_at_push_head", {mosi_data, miso_data}, q[0]);
                    data_ready = 1'b1;
                    @(posedge clk); #1;
                    data_ready = 1'b0;
                    tmp = q.pop_front();
                end
            end
            chk("pop_at_push_seen", 64'(seen), 64'd1);
        end
        wclk(8);
        model_end(mb, sb, n);
    endtask

    task automatic post_check(input string tag);
        @(negedge clk);
        chk({tag, "_armed"},    64'(armed),       64'(m_armed));
        chk({tag, "_overflow"}, 64'(overflow),    64'(m_ovf));
        chk({tag, "_len_err"},  64'(len_err_cnt), 64'(m_len));
        chk({tag, "_valid"},    64'(data_valid),  64'(q.size() != 0));
        if (q.size() != 0) chk({tag, "_head"}, 64'({mosi_data, miso_data}), 64'(q[0]));
    endtask

    task automatic drain(input string tag);
        logic [2*DATA_W-1:0] tmp;
        while (q.size() > 0) begin
            @(negedge clk);
            chk({tag, "_pop_valid"}, 64'(data_valid), 64'd1);
            chk({tag, "_pop_mosi"},  64'(mosi_data),  64'(q[0][2*DATA_W-1:DATA_W]));
            chk({tag, "_pop_miso"},  64'(miso_data),  64'(q[0][DATA_W-1:0]));
            data_ready = 1'b1;
            @(posedge clk); #1;
            data_ready = 1'b0;
            tmp = q.pop_front();
        end
        @(negedge clk);
        chk({tag, "_empty"}, 64'(data_valid), 64'd0);
    endtask

    function automatic logic [63:0] fr(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d);
        return (64'(c) << DATA_W) | 64'(d);
    endfunction

    initial begin
        logic [CMD_W-1:0]  fc;
        logic [DATA_W-1:0] fd, fs;
        int                n;
        model_reset();

        // ---- reset values ----
        rst = 1'b1; wclk(2);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_mosi", 64'(mosi_data), 64'd0);
        chk("rst_miso", 64'(miso_data), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_len", 64'(len_err_cnt), 64'd0);
        rst = 1'b0; wclk(2);

        // ---- mode 0 single-shot ----
        cmd = 8'hA5; cmd_mask = 8'hFF;
        arm(0, 0, 0);
        chk("m0_armed_after_start", 64'(armed), 64'd1);
        send_frame(fr(8'hA5, 8'h3C), fr(8'h00, 8'hC3), TOT, 0, 0);
        post_check("m0");
        drain("m0");

        // ---- modes 1..3 continuous, middle frame has wrong command ----
        for (int m = 1; m < 4; m++) begin
            do_reset();
            cmd = 8'hA5; cmd_mask = 8'hFF;
            arm(1, m[1], m[0]);
            send_frame(fr(8'hA5, 8'h11), 64'($urandom), TOT, 0, 0);
            send_frame(fr(8'h5A, 8'h22), 64'($urandom), TOT, 0, 0);
            send_frame(fr(8'hA5, 8'h33), 64'($urandom), TOT, 0, 0);
            post_check("modes");
            drain("modes");
        end

        // ---- masked compare and length errors ----
        do_reset();
        cmd = 8'hA0; cmd_mask = 8'hF0;
        arm(1, 0, 0);
        send_frame(fr(8'hA7, 8'h44), 64'h5E, TOT, 0, 0);
        post_check("mask");
        send_frame(64'h1234, 64'h0, TOT - 1, 0, 0);
        post_check("len15");
        send_frame(64'h1_A0FF, 64'h0, TOT + 1, 0, 0);
        post_check("len17");
        // bit sampled in the CSN-rising cycle must count (mode 0 and mode 3)
        send_frame(fr(8'hAB, 8'h6D), 64'h92, TOT, 1, 0);
        post_check("simul_m0");
        drain("mask");
        do_reset();
        arm(1, 1, 1);
        send_frame(fr(8'hA1, 8'hB4), 64'h2F, TOT, 1, 0);
        post_check("simul_m3");
        drain("simul_m3");

        // ---- overflow ----
        do_reset();
        cmd = 8'hA5; cmd_mask = 8'hFF;
        arm(1, 0, 0);
        for (int i = 0; i < 5; i++)
            send_frame(fr(8'hA5, 8'(8'h10 + i)), 64'($urandom), TOT, 0, 0);
        post_check("ovf");
        drain("ovf");

        // ---- full FIFO with pop in the push cycle ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            arm(0, 0, 0);
            send_frame(fr(8'hA5, 8'(8'h60 + i)), 64'($urandom), TOT, 0, 0);
        end
        post_check("full4");
        arm(0, 0, 0);
        send_frame(fr(8'hA5, 8'h64), 64'($urandom), TOT, 0, 1);
        post_check("full_pop");
        drain("full_pop");

        // ---- reset mid-SHIFT ----
        do_reset();
        arm(0, 0, 0);
        send_frame(64'h1, 64'h0, TOT - 3, 0, 0);  // leaves a length error behind
        post_check("pre_rst");
        CSN = 1'b0; wclk(4);
        for (int i = 0; i < 5; i++) put_bit(1'b1, 1'b0);
        rst = 1'b1; wclk(1);
        chk("midrst_armed", 64'(armed), 64'd0);
        chk("midrst_len", 64'(len_err_cnt), 64'd0);
        wclk(1);
        rst = 1'b0; model_reset();
        wclk(2);
        CSN = 1'b1; wclk(6);
        post_check("after_rst");
        arm(0, 0, 0);
        send_frame(fr(8'hA5, 8'h77), 64'h18, TOT, 0, 0);
        post_check("rst_clean");
        drain("rst_clean");

        // ---- start while a frame is already in progress ----
        CSN = 1'b0; wclk(4);
        for (int i = 0; i < 6; i++) put_bit(fr(8'hA5, 8'h99) >> (TOT - 1 - i), 1'b1);
        arm(1, 0, 0);
        for (int i = 6; i < TOT; i++) put_bit(fr(8'hA5, 8'h99) >> (TOT - 1 - i), 1'b1);
        wclk(4); CSN = 1'b1; wclk(8);
        post_check("inprog_ignored");
        send_frame(fr(8'hA5, 8'h55), 64'hAA, TOT, 0, 0);
        post_check("inprog_next");
        drain("inprog");

        // ---- randomized continuous traffic ----
        do_reset();
        arm(1, 1'($urandom), 1'($urandom));
        for (int it = 0; it < 14; it++) begin
            cmd      = 8'($urandom);
            cmd_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            fc = ($urandom_range(0, 3) != 0) ? (cmd ^ (8'($urandom) & ~cmd_mask)) : 8'($urandom);
            fd = 8'($urandom);
            fs = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       n = TOT - 1;
                1:       n = TOT + 1;
                2:       n = TOT + 3;
                default: n = TOT;
            endcase
            send_frame((n == TOT) ? fr(fc, fd) : 64'($urandom), fr(8'($urandom), fs), n,
                       1'($urandom_range(0, 3) == 0) && !b_cpha ? 1'b1 : 1'b0, 0);
            post_check("rand");
            if ($urandom_range(0, 2) == 0) drain("rand");
        end
        drain("rand_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
